// File: rtl/fabric_io_pkg.sv
// fabric_io_pkg: shared pad-bank constants and output-enable mask helper
package fabric_io_pkg;
    localparam int IO_WIDTH_DEF = 10;
    localparam int CTRL_BITS = 2;
    localparam int CLR_BIT = 0;
    localparam int EN_BIT = 1;
    function automatic logic [63:0] oeb_mask();
        return (64'd1 << CTRL_BITS) - 64'd1;
    endfunction
endpackage

// File: rtl/updown_en_counter.sv
// updown_en_counter: generic counter with async active-low reset, sync clear and enable
module updown_en_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clr,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] cnt
);
    logic [WIDTH-1:0] nxt;
    // clear beats enable; counting wraps naturally at the width boundary
    always_comb begin
        nxt = clr ? '0 : en ? (up ? cnt + 1'b1 : cnt - 1'b1) : cnt;
    end
    // counter register, reset immediately on resetn low
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) cnt <= '0;
        else cnt <= nxt;
    end
endmodule

// File: rtl/fabric_counter_user_design.sv
// fabric_counter_user_design: enable/clear up-counter mapped onto the I/O pad bank
module fabric_counter_user_design
    import fabric_io_pkg::*;
#(
    parameter int IO_WIDTH = IO_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [IO_WIDTH-1:0] io_in,
    output logic [IO_WIDTH-1:0] io_out,
    output logic [IO_WIDTH-1:0] io_oeb
);
    localparam int CNT_WIDTH = IO_WIDTH - CTRL_BITS;
    logic [CNT_WIDTH-1:0] ctr;
    logic unused_io;
    assign unused_io = ^io_in[IO_WIDTH-1:CTRL_BITS];
    updown_en_counter #(.WIDTH(CNT_WIDTH)) u_ctr (
        .clk    (clk),
        .resetn (resetn),
        .clr    (io_in[CLR_BIT]),
        .en     (io_in[EN_BIT]),
        .up     (1'b1),
        .cnt    (ctr)
    );
    assign io_out = {ctr, {CTRL_BITS{1'b0}}};
    assign io_oeb = IO_WIDTH'(oeb_mask());
endmodule

// File: tb/tb_fabric_counter_user_design.sv
// tb_fabric_counter_user_design: random and directed checks against a behavioural counter model
module tb_fabric_counter_user_design;
    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic [9:0] io_in = 10'h000;
    logic [9:0] io_out;
    logic [9:0] io_oeb;
    int vectors = 0;
    int errors = 0;
    int model = 0;
    bit have_reset = 1'b0;

    fabric_counter_user_design #(.IO_WIDTH(10)) dut (
        .clk    (clk),
        .resetn (resetn),
        .io_in  (io_in),
        .io_out (io_out),
        .io_oeb (io_oeb)
    );

    always #5 clk = ~clk;

    // behavioural model: integer count mod 256, clear first, then enable
    always @(posedge clk or negedge resetn) begin
        if (!resetn) model <= 0;
        else if (io_in[0]) model <= 0;
        else if (io_in[1]) model <= (model + 1) % 256;
    end

    // every falling edge after the first reset: pads must match the model
    always @(negedge clk) begin
        if (have_reset) begin
            vectors++;
            if (io_out !== 10'(model * 4) || io_oeb !== 10'h003) begin
                errors++;
                $display("FAIL cycle_cmp: io_out=%h io_oeb=%h, want io_out=%h io_oeb=003", io_out, io_oeb, 10'(model * 4));
            end
        end
    end

    task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n, input logic [9:0] v);
        @(negedge clk);
        #1 io_in = v;
        for (int i = 1; i < n; i++) @(negedge clk);
    endtask

    initial begin
        #3 resetn = 1'b0;
        #1;
        chk("reset_out", io_out, 10'h000);
        chk("reset_oeb", io_oeb, 10'h003);
        have_reset = 1'b1;
        @(negedge clk);
        #1 resetn = 1'b1;
        cycles(20, 10'h000);
        chk("reset_hold_out", io_out, 10'h000);
        chk("tristate", ~io_oeb, 10'h3FC);
        cycles(5, 10'h003);
        @(negedge clk);
        #1 io_in = 10'h002;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk("count_k", io_out, 10'(k << 2));
        end
        #1 io_in = 10'h000;
        for (int i = 0; i < 10; i++) @(negedge clk);
        chk("hold", io_out, 10'h028);
        #1 io_in = 10'h002;
        @(negedge clk);
        chk("reenable", io_out, 10'h02C);
        for (int i = 0; i < 69; i++) @(negedge clk);
        chk("at_0x50", io_out, 10'h140);
        #1 io_in = 10'h003;
        @(negedge clk);
        chk("clr_prio", io_out, 10'h000);
        for (int i = 0; i < 5; i++) @(negedge clk);
        chk("clr_held", io_out, 10'h000);
        #1 io_in = 10'h002;
        for (int i = 0; i < 255; i++) @(negedge clk);
        chk("wrap_ff", io_out, 10'h3FC);
        @(negedge clk);
        chk("wrap_00", io_out, 10'h000);
        for (int i = 0; i < 7; i++) @(negedge clk);
        chk("pre_async", io_out, 10'h01C);
        #2 resetn = 1'b0;
        #1;
        chk("async_mid", io_out, 10'h000);
        @(negedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        chk("resume_1", io_out, 10'h004);
        #1 resetn = 1'b0;
        io_in = 10'h001;
        @(negedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        chk("rel_with_clr", io_out, 10'h000);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #1 io_in = 10'($urandom) & 10'h3FE;
            if ($urandom_range(0, 15) == 0) io_in[0] = 1'b1;
            if ($urandom_range(0, 1) == 0) io_in[1] = 1'b1;
            if ($urandom_range(0, 40) == 0) begin
                #1 resetn = 1'b0;
                #1;
                chk("rand_async", io_out, 10'h000);
                #1 resetn = 1'b1;
            end
        end
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
